// File: rtl/image_decomp_pkg.sv
// Shared types and field constants for the run-length image decompressor.
package image_decomp_pkg;

  localparam int unsigned RUN_W  = 8;
  localparam int unsigned ADDR_W = 16;

  // Compressed word layout: upper byte is the zero-run, lower byte the one-run.
  localparam int unsigned IN1_MSB = 15;
  localparam int unsigned IN1_LSB = 8;
  localparam int unsigned IN2_MSB = 7;
  localparam int unsigned IN2_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ZEROS = 2'd1,
    ONES  = 2'd2,
    DONE  = 2'd3
  } decompState_e;

endpackage

// File: rtl/decomp_addr_gen.sv
// Pixel counter and RAM address register for the image decompressor.
module decomp_addr_gen
  import image_decomp_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IMG_BASE   = 16'h8000,
  parameter int unsigned       IMG_PIXELS = 784
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] address,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_PIXELS - 1);

  logic [ADDR_W-1:0] pixelCount;

  // Count written pixels; the address tracks base+count and wraps at 2^16.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      pixelCount <= '0;
      address    <= IMG_BASE;
    end else if (clear) begin
      pixelCount <= '0;
      address    <= IMG_BASE;
    end else if (advance) begin
      pixelCount <= pixelCount + 1'b1;
      address    <= address + 1'b1;
    end
  end

  assign last = (pixelCount == LAST_IDX);

endmodule

// File: rtl/image_decompressor.sv
// Run-length image decompressor: expands {zero-run, one-run} words into
// one RAM byte write per pixel. Optional feature macro: DECOMP_ONES_COUNT_EN
// (saturating count of ONE_VAL writes on ones_count).
module image_decompressor
  import image_decomp_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IMG_BASE   = 16'h8000,
  parameter int unsigned       IMG_PIXELS = 784,
  parameter logic [7:0]        ZERO_VAL   = 8'h00,
  parameter logic [7:0]        ONE_VAL    = 8'hFF
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              load,
  input  logic              cnn,
  input  logic [15:0]       Din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [7:0]        ramDataIn,
  output logic              writeSignal,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       ones_count
);

  decompState_e     state, nextState;
  logic [RUN_W-1:0] run, runNext;
  logic [RUN_W-1:0] in2Q, in2Next;
  logic [RUN_W-1:0] in1, in2;
  logic             img, imgQ, startEvt, accept;
  logic             writing, last, overflowSet, nextWrite;

  assign in1      = Din[IN1_MSB:IN1_LSB];
  assign in2      = Din[IN2_MSB:IN2_LSB];
  assign img      = load & ~cnn;
  assign startEvt = img & ~imgQ;
  assign accept   = din_valid & din_ready & img;
  assign writing  = (state == ZEROS) || (state == ONES);

  decomp_addr_gen #(
    .IMG_BASE  (IMG_BASE),
    .IMG_PIXELS(IMG_PIXELS)
  ) addrGen (
    .clk    (clk),
    .RST    (RST),
    .clear  (startEvt),
    .advance(writing),
    .address(ramAddress),
    .last   (last)
  );

  // Next-state and run bookkeeping; a write state means a write is on the bus this cycle.
  always_comb begin
    nextState   = state;
    runNext     = run;
    in2Next     = in2Q;
    overflowSet = 1'b0;
    if (startEvt) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in2Next = in2;
            if (in1 != '0) begin
              nextState = ZEROS;
              runNext   = in1;
            end else if (in2 != '0) begin
              nextState = ONES;
              runNext   = in2;
            end
          end
        end
        ZEROS: begin
          if (run == RUN_W'(1)) begin
            if (in2Q != '0) begin
              nextState = ONES;
              runNext   = in2Q;
            end else begin
              nextState = IDLE;
            end
          end else begin
            runNext = run - 1'b1;
          end
        end
        ONES: begin
          if (run == RUN_W'(1)) nextState = IDLE;
          else                  runNext   = run - 1'b1;
        end
        DONE: begin
          if (din_valid && img) overflowSet = 1'b1;
        end
        default: nextState = IDLE;
      endcase
      // Final pixel wins over a concurrent abort: that write has already been issued.
      if (writing) begin
        if (last) begin
          nextState   = DONE;
          overflowSet = (state == ZEROS) ? ((run != RUN_W'(1)) || (in2Q != '0))
                                         : (run != RUN_W'(1));
        end else if (!img) begin
          nextState = IDLE;
        end
      end
    end
  end

  assign nextWrite = (nextState == ZEROS) || (nextState == ONES);

  // State, run registers and registered outputs, all computed from next state.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      run         <= '0;
      in2Q        <= '0;
      imgQ        <= 1'b0;
      din_ready   <= 1'b0;
      writeSignal <= 1'b0;
      ramDataIn   <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= nextState;
      run         <= runNext;
      in2Q        <= in2Next;
      imgQ        <= img;
      din_ready   <= img && (nextState == IDLE) && !accept;
      writeSignal <= nextWrite;
      if (nextWrite) ramDataIn <= (nextState == ONES) ? ONE_VAL : ZERO_VAL;
      if (startEvt) begin
        done     <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (nextState == DONE) done     <= 1'b1;
        if (overflowSet)       overflow <= 1'b1;
      end
    end
  end

`ifdef DECOMP_ONES_COUNT_EN
  // Saturating count of ONE_VAL writes, cleared on each new image.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      ones_count <= '0;
    end else if (startEvt) begin
      ones_count <= '0;
    end else if ((state == ONES) && (ones_count != '1)) begin
      ones_count <= ones_count + 1'b1;
    end
  end
`else
  assign ones_count = '0;
`endif

endmodule

// File: tb/tb_image_decompressor.sv
// Directed self-checking bench for image_decompressor (default and 4-pixel builds).
module tb_image_decompressor;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        load = 1'b0;
  logic        cnn = 1'b0;
  logic [15:0] Din = '0;
  logic        din_valid = 1'b0;

  logic        din_ready,  writeSignal,  done,  overflow;
  logic [15:0] ramAddress, ones_count;
  logic [7:0]  ramDataIn;
  logic        din_ready2, writeSignal2, done2, overflow2;
  logic [15:0] ramAddress2, ones_count2;
  logic [7:0]  ramDataIn2;

  int vectors = 0;
  int miscompares = 0;

`ifdef DECOMP_ONES_COUNT_EN
  localparam logic [15:0] ONES_0302 = 16'd2;
`else
  localparam logic [15:0] ONES_0302 = 16'd0;
`endif

  always #5 clk = ~clk;

  image_decompressor dut (
    .clk(clk), .RST(RST), .load(load), .cnn(cnn), .Din(Din), .din_valid(din_valid),
    .din_ready(din_ready), .ramAddress(ramAddress), .ramDataIn(ramDataIn),
    .writeSignal(writeSignal), .done(done), .overflow(overflow), .ones_count(ones_count)
  );

  image_decompressor #(.IMG_PIXELS(4)) dut4 (
    .clk(clk), .RST(RST), .load(load), .cnn(cnn), .Din(Din), .din_valid(din_valid),
    .din_ready(din_ready2), .ramAddress(ramAddress2), .ramDataIn(ramDataIn2),
    .writeSignal(writeSignal2), .done(done2), .overflow(overflow2), .ones_count(ones_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drop load for one cycle then raise it: produces a start event on both DUTs.
  task automatic restart();
    din_valid = 1'b0;
    cnn  = 1'b0;
    load = 1'b0;
    tick();
    load = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    vectors++;
    if ({din_ready, writeSignal, done, overflow} !== 4'b0000 || ramAddress !== 16'h8000 ||
        ramDataIn !== 8'h00 || ones_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_init: rdy=%b wr=%b done=%b ovf=%b addr=%h data=%h ones=%h, want 0 0 0 0 8000 00 0000",
               din_ready, writeSignal, done, overflow, ramAddress, ramDataIn, ones_count);
    end
    RST = 1'b1;
    load = 1'b1;
    tick();
    Din = 16'h0A00;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    tick();
    vectors++;
    if (writeSignal !== 1'b1 || ramAddress !== 16'h8002) begin
      miscompares++;
      $display("FAIL reset_prerun: wr=%b addr=%h, want 1 8002", writeSignal, ramAddress);
    end
    #2 RST = 1'b0;
    #1;
    vectors++;
    if ({din_ready, writeSignal, done, overflow} !== 4'b0000 || ramAddress !== 16'h8000 ||
        ramDataIn !== 8'h00 || ones_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_async: rdy=%b wr=%b done=%b ovf=%b addr=%h data=%h ones=%h, want 0 0 0 0 8000 00 0000",
               din_ready, writeSignal, done, overflow, ramAddress, ramDataIn, ones_count);
    end
    tick();
    RST = 1'b1;
    tick();
    vectors++;
    if (din_ready !== 1'b1 || writeSignal !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: rdy=%b wr=%b, want 1 0", din_ready, writeSignal);
    end
  endtask

  task automatic test_word0302();
    logic [7:0]  expData [5] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    logic [15:0] expAddr;
    restart();
    Din = 16'h0302;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expAddr = 16'h8000 + 16'(k);
      vectors++;
      if (writeSignal !== 1'b1 || ramAddress !== expAddr || ramDataIn !== expData[k] || din_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL word0302_px%0d: wr=%b addr=%h data=%h rdy=%b, want 1 %h %h 0",
                 k, writeSignal, ramAddress, ramDataIn, din_ready, expAddr, expData[k]);
      end
      tick();
    end
    vectors++;
    if (writeSignal !== 1'b0 || din_ready !== 1'b1 || ones_count !== ONES_0302 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL word0302_end: wr=%b rdy=%b ones=%h done=%b, want 0 1 %h 0",
               writeSignal, din_ready, ones_count, ONES_0302, done);
    end
  endtask

  task automatic test_empty_word();
    restart();
    Din = 16'h0000;
    din_valid = 1'b1;
    tick();
    vectors++;
    if (din_ready !== 1'b0 || writeSignal !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_n1: rdy=%b wr=%b, want 0 0", din_ready, writeSignal);
    end
    Din = 16'h0001;
    tick();
    vectors++;
    if (din_ready !== 1'b1 || writeSignal !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_n2: rdy=%b wr=%b, want 1 0", din_ready, writeSignal);
    end
    tick();
    din_valid = 1'b0;
    vectors++;
    if (writeSignal !== 1'b1 || ramAddress !== 16'h8000 || ramDataIn !== 8'hFF || din_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_one: wr=%b addr=%h data=%h rdy=%b, want 1 8000 ff 0",
               writeSignal, ramAddress, ramDataIn, din_ready);
    end
    tick();
    vectors++;
    if (writeSignal !== 1'b0 || din_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_after: wr=%b rdy=%b, want 0 1", writeSignal, din_ready);
    end
  endtask

  task automatic test_last_pixel();
    logic [7:0]  expData [4] = '{8'h00, 8'h00, 8'h00, 8'hFF};
    logic [15:0] expAddr;
    restart();
    Din = 16'h0303;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expAddr = 16'h8000 + 16'(k);
      vectors++;
      if (writeSignal2 !== 1'b1 || ramAddress2 !== expAddr || ramDataIn2 !== expData[k]) begin
        miscompares++;
        $display("FAIL last_px%0d: wr=%b addr=%h data=%h, want 1 %h %h",
                 k, writeSignal2, ramAddress2, ramDataIn2, expAddr, expData[k]);
      end
      tick();
    end
    vectors++;
    if (writeSignal2 !== 1'b0 || done2 !== 1'b1 || overflow2 !== 1'b1 || din_ready2 !== 1'b0) begin
      miscompares++;
      $display("FAIL last_done: wr=%b done=%b ovf=%b rdy=%b, want 0 1 1 0",
               writeSignal2, done2, overflow2, din_ready2);
    end
    Din = 16'h0001;
    din_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (writeSignal2 !== 1'b0 || din_ready2 !== 1'b0 || done2 !== 1'b1) begin
        miscompares++;
        $display("FAIL last_drop%0d: wr=%b rdy=%b done=%b, want 0 0 1", k, writeSignal2, din_ready2, done2);
      end
    end
    din_valid = 1'b0;
    // Exact fit: four ones end the image with no overflow until an extra word shows up.
    restart();
    Din = 16'h0004;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (4) tick();
    vectors++;
    if (done2 !== 1'b1 || overflow2 !== 1'b0 || ramDataIn2 !== 8'hFF) begin
      miscompares++;
      $display("FAIL exact_fit: done=%b ovf=%b data=%h, want 1 0 ff", done2, overflow2, ramDataIn2);
    end
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    vectors++;
    if (overflow2 !== 1'b1 || writeSignal2 !== 1'b0) begin
      miscompares++;
      $display("FAIL extra_word: ovf=%b wr=%b, want 1 0", overflow2, writeSignal2);
    end
    load = 1'b0;
    tick();
    tick();
    vectors++;
    if (done2 !== 1'b1) begin
      miscompares++;
      $display("FAIL done_held: done=%b, want 1", done2);
    end
    load = 1'b1;
    tick();
    vectors++;
    if (done2 !== 1'b0 || overflow2 !== 1'b0 || ramAddress2 !== 16'h8000) begin
      miscompares++;
      $display("FAIL restart_clear: done=%b ovf=%b addr=%h, want 0 0 8000", done2, overflow2, ramAddress2);
    end
  endtask

  task automatic test_cnn();
    restart();
    cnn = 1'b1;
    tick();
    tick();
    Din = 16'h0101;
    for (int i = 0; i < 6; i++) begin
      din_valid = i[0];
      vectors++;
      if (writeSignal !== 1'b0 || din_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL cnn_cyc%0d: wr=%b rdy=%b, want 0 0", i, writeSignal, din_ready);
      end
      tick();
    end
    din_valid = 1'b0;
    cnn = 1'b0;
  endtask

  task automatic test_abort();
    restart();
    Din = 16'h0500;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    vectors++;
    if (writeSignal !== 1'b1 || ramAddress !== 16'h8000) begin
      miscompares++;
      $display("FAIL abort_px0: wr=%b addr=%h, want 1 8000", writeSignal, ramAddress);
    end
    tick();
    vectors++;
    if (writeSignal !== 1'b1 || ramAddress !== 16'h8001) begin
      miscompares++;
      $display("FAIL abort_px1: wr=%b addr=%h, want 1 8001", writeSignal, ramAddress);
    end
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (writeSignal !== 1'b0 || ramAddress !== 16'h8002 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_stop%0d: wr=%b addr=%h done=%b, want 0 8002 0", i, writeSignal, ramAddress, done);
      end
    end
    load = 1'b1;
    tick();
    vectors++;
    if (din_ready !== 1'b1 || ramAddress !== 16'h8000) begin
      miscompares++;
      $display("FAIL abort_restart: rdy=%b addr=%h, want 1 8000", din_ready, ramAddress);
    end
    Din = 16'h0001;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    vectors++;
    if (writeSignal !== 1'b1 || ramAddress !== 16'h8000 || ramDataIn !== 8'hFF) begin
      miscompares++;
      $display("FAIL abort_newword: wr=%b addr=%h data=%h, want 1 8000 ff", writeSignal, ramAddress, ramDataIn);
    end
  endtask

  initial begin
    test_reset();
    test_word0302();
    test_empty_word();
    test_last_pixel();
    test_cnn();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/image_decompressor.md
# image_decompressor

Run-length image decompressor in the load path. It accepts 16-bit compressed image words (`in1`/`in2` run pairs) while `load`=1 and `cnn`=0. It expands each word into one RAM byte write per pixel, at sequential addresses from the image base. It sits between the coordinator's `Din` input and the shared RAM write port, and consumes the compressed image stream after the CNN parameters are loaded.

## Interface
- `IMG_BASE`, 16'h8000, RAM byte address of pixel 0.
- `IMG_PIXELS`, 784, total pixels per image (1..65535).
- `ZERO_VAL`, 8'h00, byte written for a 0 pixel.
- `ONE_VAL`, 8'hFF, byte written for a 1 pixel.
- `clk`  in  1  rising-edge clock.
- `RST`  in  1  asynchronous, active-low reset (0 = reset).
- `load`  in  1  load window; image mode when `cnn`=0.
- `cnn`  in  1  1 = parameter load (block ignores input), 0 = image load.
- `Din`  in  16  compressed word; `Din[15:8]`=`in1` (zero-run length), `Din[7:0]`=`in2` (one-run length).
- `din_valid`  in  1  `Din` valid this cycle.
- `din_ready`  out  1  block can accept a word this cycle.
- `ramAddress`  out  16  write address.
- `ramDataIn`  out  8  write data.
- `writeSignal`  out  1  write strobe, one byte per cycle.
- `done`  out  1  all `IMG_PIXELS` pixels written.
- `overflow`  out  1  sticky; pixels or words arrived beyond `IMG_PIXELS`.
- `ones_count`  out  16  number of 1 pixels written (see Configuration).

## Operation
- Image mode: `img` = `load` & ~`cnn`. Start event: `img` rises (registered compare).
- A start event clears the pixel counter, address, `done`, `overflow` and `ones_count`, and enters IDLE.
- A word is accepted when `din_valid` & `din_ready`. `din_ready` = `img` & state==IDLE.
- FSM states: IDLE, ZEROS, ONES, DONE.
  - IDLE: on accept, latch `in1`/`in2`. Go to ZEROS if `in1`≠0, else ONES if `in2`≠0, else stay in IDLE (empty word, no writes).
  - ZEROS: write `ZERO_VAL` each cycle and decrement the run. At run=1, go to ONES if `in2`≠0, else IDLE.
  - ONES: write `ONE_VAL` each cycle. At run=1, go to IDLE.
  - Any state: when the write of pixel `IMG_PIXELS`-1 occurs, go to DONE. If run pixels remain, set `overflow`.
  - DONE: `done`=1, `din_ready`=0. A `din_valid` here sets `overflow`, and the word is dropped.
- Address = `IMG_BASE` + pixel index. It is 16 bits and wraps modulo 2^16 with no error.
- `img` falls mid-run: abort at the next edge and go to IDLE. The partial word is discarded, and the counter and `done` are held. `done` stays visible after `load` drops until the next start event.
- `cnn`=1: no writes and `din_ready`=0, regardless of `load`.

## Timing
- Reset values: `din_ready`=0, `ramAddress`=`IMG_BASE`, `ramDataIn`=0, `writeSignal`=0, `done`=0, `overflow`=0, `ones_count`=0. State is IDLE.
- All outputs are registered.
- First write: cycle N+1 after acceptance in cycle N.
- A word with `in1`+`in2`=k>0 occupies k write cycles, N+1..N+k. `din_ready` reasserts in cycle N+k+1.
- An empty word gives `din_ready` low for one cycle only (N+1).
- Throughput is one pixel per clock. Maximum word cost is 510 cycles. Upstream must hold `Din`/`din_valid` until it sees `din_ready`.
- `done` rises in the cycle after the final write.

## Configuration
- `DECOMP_ONES_COUNT_EN` defined: `ones_count` increments on every `ONE_VAL` write and saturates at 16'hFFFF. It is used as a cheap image checksum.
- `DECOMP_ONES_COUNT_EN` undefined: the counter logic is omitted and `ones_count` is tied to 0.

## Structure
- Package `image_decomp_pkg` holds:
  - the FSM state enum;
  - `IN1_MSB`/`IN1_LSB`/`IN2_MSB`/`IN2_LSB` field constants;
  - `RUN_W`=8 and `ADDR_W`=16.
- Sub-module `decomp_addr_gen` holds the pixel counter, address register and last-pixel compare.
  - Inputs: clear and advance.
  - Outputs: address and last.
  - The FSM and run counters stay in `image_decompressor`.

## Test plan
- Reset mid-run: `RST`=0 in ZEROS -> all outputs return to reset values asynchronously; state is IDLE.
- Word 16'h0302 -> writes 00,00,00,FF,FF at 8000..8004. `din_ready` low for 5 cycles. `ones_count`=2.
- Word 16'h0000, then 16'h0001 -> no write for the first word. One FF write at 8000, issued 2 cycles after the first acceptance.
- `IMG_PIXELS`=4 and word 16'h0303 -> 4 writes (00,00,00,FF). `done`=1 and `overflow`=1. A later `din_valid` is not accepted.
- `cnn`=1, `load`=1 with `din_valid` pulses -> `writeSignal` never asserts and `din_ready`=0.
- `load` dropped after 2 pixels of word 16'h0500, then reasserted -> writes stop. The restart clears the counter, and the next word writes from 8000.
